// File: rtl/paddle_bank_if.sv
// paddle_bank_if: pixel position, paddle control, positions and RGB between the game logic and paddle_bank
interface paddle_bank_if #(
  parameter int NUM_PAD = 2,
  parameter int COORD_W = 10
);
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic [NUM_PAD-1:0] pad_move;
  logic [NUM_PAD-1:0] pad_up;
  logic [NUM_PAD*COORD_W-1:0] pad_x;
  logic [NUM_PAD*24-1:0] pad_color;
  logic up_p;
  logic center;
  logic draw_p;
  logic [NUM_PAD*COORD_W-1:0] pad_y;
  logic [NUM_PAD-1:0] at_edge;
  logic frame_tick;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  modport master (
    output row, col, pad_move, pad_up, pad_x, pad_color, up_p, center, draw_p,
    input pad_y, at_edge, frame_tick, red, green, blue
  );
  modport slave (
    input row, col, pad_move, pad_up, pad_x, pad_color, up_p, center, draw_p,
    output pad_y, at_edge, frame_tick, red, green, blue
  );
endinterface

// File: rtl/paddle_bank.sv
// paddle_bank: NUM_PAD frame-stepped vertical paddles with renderer; PADDLE_ACCEL_EN enables per-paddle step acceleration
module paddle_bank #(
  parameter int NUM_PAD  = 2,
  parameter int COORD_W  = 10,
  parameter int PAD_H    = 48,
  parameter int PAD_W    = 4,
  parameter int STEP     = 5,
  parameter int MAX_STEP = 12,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 550,
  parameter int Y_CENTER = 275,
  parameter int H_LAST   = 799,
  parameter int V_LAST   = 599
) (
  input logic clock,
  input logic reset,
  paddle_bank_if.slave bus
);
  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W-1:0] YMIN = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] YC   = COORD_W'(Y_CENTER);
  localparam logic [COORD_W-1:0] STP  = COORD_W'(STEP);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN} state_t;
  state_t st_q[NUM_PAD];
  state_t st_d[NUM_PAD];
  logic [COORD_W-1:0] y_q[NUM_PAD];
  logic [COORD_W-1:0] y_d[NUM_PAD];
  logic [COORD_W-1:0] step_q[NUM_PAD];
  logic [COORD_W-1:0] step_d[NUM_PAD];
  logic [NUM_PAD-1:0] mv_q, mv_d, dir_q, dir_d, edge_q, edge_d;
  logic [23:0] rgb_q, rgb_d;
  logic tick, upd;
  // Saturating move at one extra bit so neither bound can wrap
  function automatic logic [COORD_W-1:0] step_to(input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] s, input logic up);
    logic [CW1-1:0] ye, se;
    ye = {1'b0, y};
    se = {1'b0, s};
    step_to = up ? ((ye < se + CW1'(Y_MIN)) ? YMIN : COORD_W'(ye - se))
                 : ((ye + se > CW1'(Y_MAX)) ? YMAX : COORD_W'(ye + se));
  endfunction
  assign tick = (bus.row == COORD_W'(V_LAST)) && (bus.col == COORD_W'(H_LAST));
  assign upd = tick && (bus.up_p || bus.center);
  assign bus.frame_tick = tick;
  assign bus.at_edge = edge_q;
  assign {bus.red, bus.green, bus.blue} = rgb_q;
  for (genvar g = 0; g < NUM_PAD; g++) begin : g_pack
    assign bus.pad_y[g*COORD_W +: COORD_W] = y_q[g];
  end
  // Per-frame shadow capture, position update and direction FSM
  always_comb begin
    mv_d = tick ? bus.pad_move : mv_q;
    dir_d = tick ? bus.pad_up : dir_q;
    for (int i = 0; i < NUM_PAD; i++) begin
      y_d[i] = y_q[i];
      st_d[i] = st_q[i];
      step_d[i] = step_q[i];
      if (upd) begin
        if (bus.center) begin
          y_d[i] = YC;
          st_d[i] = IDLE;
          step_d[i] = STP;
        end else if (mv_q[i]) begin
          st_d[i] = dir_q[i] ? MOVE_UP : MOVE_DN;
`ifdef PADDLE_ACCEL_EN
          if (st_q[i] != IDLE && st_q[i] != st_d[i]) begin
            y_d[i] = step_to(y_q[i], STP, dir_q[i]);
            step_d[i] = STP;
          end else begin
            y_d[i] = step_to(y_q[i], step_q[i], dir_q[i]);
            step_d[i] = (step_q[i] >= COORD_W'(MAX_STEP)) ? COORD_W'(MAX_STEP) : step_q[i] + 1'b1;
          end
`else
          y_d[i] = step_to(y_q[i], step_q[i], dir_q[i]);
          step_d[i] = STP;
`endif
        end else begin
          st_d[i] = IDLE;
          step_d[i] = STP;
        end
      end
      edge_d[i] = (y_d[i] == YMIN) || (y_d[i] == YMAX);
    end
  end
  // Renderer: lowest-index covering paddle wins, so scan from the top index down
  always_comb begin
    rgb_d = '0;
    for (int i = NUM_PAD - 1; i >= 0; i--) begin
      if (bus.draw_p
          && {1'b0, bus.col} >= {1'b0, bus.pad_x[i*COORD_W +: COORD_W]}
          && {1'b0, bus.col} <= {1'b0, bus.pad_x[i*COORD_W +: COORD_W]} + CW1'(PAD_W - 1)
          && {1'b0, bus.row} >= {1'b0, y_q[i]}
          && {1'b0, bus.row} <= {1'b0, y_q[i]} + CW1'(PAD_H - 1))
        rgb_d = bus.pad_color[i*24 +: 24];
    end
  end
  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PAD; i++) begin
        y_q[i] <= YC;
        st_q[i] <= IDLE;
        step_q[i] <= STP;
      end
      mv_q <= '0;
      dir_q <= '0;
      edge_q <= '0;
      rgb_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PAD; i++) begin
        y_q[i] <= y_d[i];
        st_q[i] <= st_d[i];
        step_q[i] <= step_d[i];
      end
      mv_q <= mv_d;
      dir_q <= dir_d;
      edge_q <= edge_d;
      rgb_q <= rgb_d;
    end
  end
endmodule
